// File: rtl/snake_direction_input_pkg.sv
// Shared direction encodings and helpers for the snake input front-end and game core.
// One-hot directions: [0]=up [1]=down [2]=left [3]=right.
package snake_direction_input_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Swaps up<->down and left<->right.
    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic logic [3:0] dir_priority(input logic [3:0] p);
        logic [3:0] r;
        r = DIR_NONE;
        if (p[0])      r = DIR_UP;
        else if (p[1]) r = DIR_DOWN;
        else if (p[2]) r = DIR_LEFT;
        else if (p[3]) r = DIR_RIGHT;
        return r;
    endfunction

endpackage

// File: rtl/snake_direction_input_button_debounce.sv
// One pushbutton: 2-FF synchroniser, stability-count debounce, rising-edge press pulse.
// Press appears 2 + DEBOUNCE_CYCLES cycles after a clean raw edge.
module button_debounce
    import snake_direction_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic i_clock,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any return to the current level drops the partial count, so glitches never land.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/snake_direction_input.sv
// Snake input front-end: debounced buttons -> pending press -> at most one turn command per step.
// Commands and rejects are registered at the step cycle and visible the cycle after.
module snake_direction_input
    import snake_direction_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_DIV        = 8,
    parameter int CNT_W           = 16
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic [3:0] i_button,
    output logic [3:0] o_switch,
    output logic [3:0] o_heading,
    output logic       o_step,
    output logic       o_rejected
);

    logic [3:0]       w_press;
    logic [3:0]       w_level_unused;
    logic [3:0]       w_press_oh;
    logic             w_step;
    logic [3:0]       w_next_switch;
    logic [3:0]       w_next_heading;
    logic             w_next_rejected;

    logic [CNT_W-1:0] r_step_cnt;
    logic [3:0]       r_pending;
    logic [3:0]       r_switch;
    logic [3:0]       r_heading;
    logic             r_rejected;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .i_clock(i_clock),
            .i_rst_n(i_rst_n),
            .i_raw  (i_button[g]),
            .o_level(w_level_unused[g]),
            .o_press(w_press[g])
        );
    end

    assign w_press_oh = dir_priority(w_press);
    assign w_step     = (r_step_cnt == CNT_W'(STEP_DIV - 1));

    always_comb begin
        w_next_switch   = r_switch;
        w_next_heading  = r_heading;
        w_next_rejected = 1'b0;
        if (w_step) begin
            w_next_switch = DIR_NONE;
            if (r_pending == DIR_NONE || r_pending == r_heading) begin
                w_next_switch = DIR_NONE;
            end else if (r_pending == dir_opposite(r_heading)) begin
                w_next_rejected = 1'b1;
            end else begin
                w_next_switch  = r_pending;
                w_next_heading = r_pending;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_cnt <= '0;
            r_pending  <= DIR_NONE;
            r_switch   <= DIR_NONE;
            r_heading  <= DIR_RIGHT;
            r_rejected <= 1'b0;
        end else begin
            r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
            // A press landing on the step cycle survives into the next window.
            if (w_step || (|w_press)) begin
                r_pending <= w_press_oh;
            end
            r_switch   <= w_next_switch;
            r_heading  <= w_next_heading;
            r_rejected <= w_next_rejected;
        end
    end

    assign o_switch   = r_switch;
    assign o_heading  = r_heading;
    assign o_step     = w_step;
    assign o_rejected = r_rejected;

endmodule

// File: tb/tb_snake_direction_input.sv
module tb_snake_direction_input;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button = 4'b0000;
    logic [3:0] sw;
    logic [3:0] heading;
    logic       step;
    logic       rejected;

    int checks = 0;
    int failures = 0;

    snake_direction_input #(
        .DEBOUNCE_CYCLES(4),
        .STEP_DIV       (8),
        .CNT_W          (16)
    ) dut (
        .i_clock   (clk),
        .i_rst_n   (rst_n),
        .i_button  (button),
        .o_switch  (sw),
        .o_heading (heading),
        .o_step    (step),
        .o_rejected(rejected)
    );

    always #5 clk = ~clk;

    // Leaves reset released at a falling edge; step counter is 0 there.
    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        button = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sw, heading, step, rejected} !== {4'b0000, 4'b1000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got sw=%b hd=%b st=%b rj=%b want 0000 1000 0 0", sw, heading, step, rejected);
        end
    endtask

    task automatic test_idle_steps();
        do_reset();
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            checks++;
            if (step !== (i % 8 == 7) || sw !== 4'b0000 || heading !== 4'b1000) begin
                failures++;
                $display("FAIL idle_cycle%0d: got st=%b sw=%b hd=%b want st=%b sw=0000 hd=1000", i, step, sw, heading, (i % 8 == 7));
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sw, heading, step, rejected} !== {4'b0000, 4'b1000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_idle: got sw=%b hd=%b st=%b rj=%b want 0000 1000 0 0", sw, heading, step, rejected);
        end
    endtask

    task automatic test_hold_up();
        logic [3:0] exp_sw;
        logic [3:0] exp_hd;
        do_reset();
        button = 4'b0001;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 20) button = 4'b0000;
            exp_sw = (i >= 8 && i <= 15) ? 4'b0001 : 4'b0000;
            exp_hd = (i >= 8) ? 4'b0001 : 4'b1000;
            checks++;
            if (sw !== exp_sw || heading !== exp_hd) begin
                failures++;
                $display("FAIL hold_up_cycle%0d: got sw=%b hd=%b want sw=%b hd=%b", i, sw, heading, exp_sw, exp_hd);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (heading !== 4'b1000 || sw !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_heading: got sw=%b hd=%b want 0000 1000", sw, heading);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        button = 4'b0100;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 2) button = 4'b0000;
            checks++;
            if (sw !== 4'b0000 || heading !== 4'b1000 || rejected !== 1'b0) begin
                failures++;
                $display("FAIL glitch_cycle%0d: got sw=%b hd=%b rj=%b want 0000 1000 0", i, sw, heading, rejected);
            end
        end
    endtask

    task automatic test_reversal();
        do_reset();
        button = 4'b0100;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) button = 4'b0000;
            checks++;
            if (rejected !== (i == 8) || sw !== 4'b0000 || heading !== 4'b1000) begin
                failures++;
                $display("FAIL reversal_cycle%0d: got rj=%b sw=%b hd=%b want rj=%b sw=0000 hd=1000", i, rejected, sw, heading, (i == 8));
            end
        end
    endtask

    task automatic test_latest_wins();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2)  button = 4'b0001;
            if (i == 4)  button = 4'b0011;
            if (i == 12) button = 4'b0000;
            if (i == 8) begin
                checks++;
                if (sw !== 4'b0000 || heading !== 4'b1000) begin
                    failures++;
                    $display("FAIL latest_first_step: got sw=%b hd=%b want 0000 1000", sw, heading);
                end
            end
            if (i == 16) begin
                checks++;
                if (sw !== 4'b0010 || heading !== 4'b0010) begin
                    failures++;
                    $display("FAIL latest_wins: got sw=%b hd=%b want 0010 0010", sw, heading);
                end
            end
        end
    endtask

    task automatic test_same_cycle_priority();
        do_reset();
        button = 4'b0101;
        repeat (8) @(negedge clk);
        checks++;
        if (sw !== 4'b0001 || heading !== 4'b0001) begin
            failures++;
            $display("FAIL same_cycle_priority: got sw=%b hd=%b want 0001 0001", sw, heading);
        end
        button = 4'b0000;
    endtask

    task automatic test_step_collision();
        do_reset();
        button = 4'b0001;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1)  button = 4'b0101;
            if (i == 12) button = 4'b0000;
            if (i == 8) begin
                checks++;
                if (sw !== 4'b0001 || heading !== 4'b0001) begin
                    failures++;
                    $display("FAIL collision_old_pending: got sw=%b hd=%b want 0001 0001", sw, heading);
                end
            end
            if (i == 16) begin
                checks++;
                if (sw !== 4'b0100 || heading !== 4'b0100) begin
                    failures++;
                    $display("FAIL collision_new_press: got sw=%b hd=%b want 0100 0100", sw, heading);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        button = 4'b0001;
        repeat (7) @(negedge clk);
        checks++;
        if (step !== 1'b1) begin
            failures++;
            $display("FAIL pending_step_phase: got st=%b want 1", step);
        end
        rst_n  = 1'b0;
        button = 4'b0000;
        #1;
        checks++;
        if ({sw, heading, step, rejected} !== {4'b0000, 4'b1000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_step: got sw=%b hd=%b st=%b rj=%b want 0000 1000 0 0", sw, heading, step, rejected);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            checks++;
            if (sw !== 4'b0000 || heading !== 4'b1000 || step !== (i % 8 == 7)) begin
                failures++;
                $display("FAIL pending_lost_cycle%0d: got sw=%b hd=%b st=%b want 0000 1000 %b", i, sw, heading, step, (i % 8 == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_steps();
        test_hold_up();
        test_glitch();
        test_reversal();
        test_latest_wins();
        test_same_cycle_priority();
        test_step_collision();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
